// File: rtl/aes_mode_ctrl.sv
// Multi-block AES-128 engine: ECB/CBC/CTR chaining around one iterative core,
// valid/ready streaming on both sides and a small output FIFO.
// Also contains the iterative single-block core "aes" that the wrapper drives.

// Iterative AES-128 encryptor: one round per clock, result pulse 11 cycles after start.
module aes (
    input  logic         clk,
    input  logic         resetn,
    input  logic         data_valid_in,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         res_valid_out,
    output logic [127:0] res_enc_out
);
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [7:0]   rcon_reg;
    logic [3:0]   round_reg;
    logic         run_reg;
    logic         valid_reg;

    logic [31:0]  key_t;
    logic [127:0] key_next;
    logic [127:0] sub_sr;
    logic [127:0] mixed;
    logic [127:0] round_out;

    // Round-key schedule: RotWord + SubWord of the last word, xor rcon, then ripple.
    assign key_t = {sbox(key_reg[23:16]) ^ rcon_reg, sbox(key_reg[15:8]),
                    sbox(key_reg[7:0]), sbox(key_reg[31:24])};
    assign key_next[127:96] = key_reg[127:96] ^ key_t;
    assign key_next[95:64]  = key_reg[95:64]  ^ key_next[127:96];
    assign key_next[63:32]  = key_reg[63:32]  ^ key_next[95:64];
    assign key_next[31:0]   = key_reg[31:0]   ^ key_next[63:32];

    // SubBytes fused with ShiftRows: output byte (row r, col c) takes input (r, c+r mod 4).
    for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
        assign sub_sr[127 - 8*gi -: 8] = sbox(state_reg[127 - 8*SRC -: 8]);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
        assign mixed[127 - 32*gi -: 32] = mix_col(sub_sr[127 - 32*gi -: 32]);
    end

    // The final round skips MixColumns.
    assign round_out = ((round_reg == 4'd10) ? sub_sr : mixed) ^ key_next;

    assign res_valid_out = valid_reg;
    assign res_enc_out   = state_reg;

    // Start loads the whitened block; then ten rounds run back to back.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= '0;
            key_reg   <= '0;
            rcon_reg  <= '0;
            round_reg <= '0;
            run_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (data_valid_in) begin
                state_reg <= data_in ^ key_in;
                key_reg   <= key_in;
                rcon_reg  <= 8'h01;
                round_reg <= 4'd1;
                run_reg   <= 1'b1;
            end else if (run_reg) begin
                state_reg <= round_out;
                key_reg   <= key_next;
                rcon_reg  <= xtime(rcon_reg);
                round_reg <= round_reg + 4'd1;
                if (round_reg == 4'd10) begin
                    run_reg   <= 1'b0;
                    valid_reg <= 1'b1;
                end
            end
        end
    end
endmodule

// Mode controller: accepts a message config, feeds blocks one at a time to the core.
module aes_mode_ctrl #(
    parameter int CTR_W     = 32,
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [127:0]     cfg_key,
    input  logic [127:0]     cfg_iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err_mode,
    output logic [CNT_W-1:0] block_cnt
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_IN = 2'd1;
    localparam logic [1:0] CORE    = 2'd2;

    localparam logic [1:0] MODE_ECB = 2'd0;
    localparam logic [1:0] MODE_CBC = 2'd1;
    localparam logic [1:0] MODE_CTR = 2'd2;

    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int FCNT_W = $clog2(OUT_DEPTH + 1);

    logic [1:0]       state_reg;
    logic [1:0]       mode_reg;
    logic [127:0]     key_reg;
    logic [127:0]     chain_reg;
    logic [127:0]     data_reg;
    logic             last_reg;
    logic             start_reg;
    logic             err_reg;
    logic [CNT_W-1:0] block_cnt_reg;

    // Small FIFO held in registers so the head is visible in the same cycle it lands.
    logic [128:0]      fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [FCNT_W-1:0] fifo_count_reg;

    logic         core_valid;
    logic [127:0] core_res;
    logic [127:0] core_din;
    logic [127:0] result;
    logic         push;
    logic         pop;

    assign cfg_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    // Slot is reserved at accept time, so a push can never hit a full FIFO.
    assign in_ready  = (state_reg == WAIT_IN) && (fifo_count_reg < FCNT_W'(OUT_DEPTH));
    assign err_mode  = err_reg;
    assign block_cnt = block_cnt_reg;
    assign out_valid = (fifo_count_reg != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr_reg][128:1] : '0;
    assign out_last  = out_valid ? fifo_mem[rd_ptr_reg][0] : 1'b0;
    assign push      = (state_reg == CORE) && core_valid;
    assign pop       = out_valid && out_ready;

    // Core input and post-core result per chaining mode.
    always_comb begin
        core_din = data_reg;
        result   = core_res;
        case (mode_reg)
            MODE_CBC: core_din = data_reg ^ chain_reg;
            MODE_CTR: begin
                core_din = chain_reg;
                result   = core_res ^ data_reg;
            end
            default: ;
        endcase
    end

    aes u_core (
        .clk           (clk),
        .resetn        (~reset),
        .data_valid_in (start_reg),
        .data_in       (core_din),
        .key_in        (key_reg),
        .res_valid_out (core_valid),
        .res_enc_out   (core_res)
    );

    // Message FSM: config latch, block accept, result collection and chaining.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_ECB;
            key_reg       <= '0;
            chain_reg     <= '0;
            data_reg      <= '0;
            last_reg      <= 1'b0;
            start_reg     <= 1'b0;
            err_reg       <= 1'b0;
            block_cnt_reg <= '0;
        end else begin
            err_reg   <= 1'b0;
            start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_mode == 2'd3) begin
                            err_reg <= 1'b1;
                        end else begin
                            key_reg       <= cfg_key;
                            mode_reg      <= cfg_mode;
                            chain_reg     <= cfg_iv;
                            block_cnt_reg <= '0;
                            state_reg     <= WAIT_IN;
                        end
                    end
                end
                WAIT_IN: begin
                    if (in_valid && in_ready) begin
                        data_reg  <= in_data;
                        last_reg  <= in_last;
                        start_reg <= 1'b1;
                        state_reg <= CORE;
                    end
                end
                CORE: begin
                    if (core_valid) begin
                        if (mode_reg == MODE_CBC) begin
                            chain_reg <= core_res;
                        end else if (mode_reg == MODE_CTR) begin
                            chain_reg[CTR_W-1:0] <= chain_reg[CTR_W-1:0] + CTR_W'(1);
                        end
                        block_cnt_reg <= block_cnt_reg + CNT_W'(1);
                        state_reg     <= last_reg ? IDLE : WAIT_IN;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + FCNT_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - FCNT_W'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage write; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {result, last_reg};
        end
    end
endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl: table of known-answer blocks plus
// hand-written backpressure, CTR wrap, illegal-mode and mid-message reset sequences.
module tb_aes_mode_ctrl;
    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [1:0]   cfg_mode;
    logic [127:0] cfg_key;
    logic [127:0] cfg_iv;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;
    logic         err_mode;
    logic [15:0]  block_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_mode_ctrl #(.CTR_W(32), .OUT_DEPTH(2), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_key   (cfg_key),
        .cfg_iv    (cfg_iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err_mode  (err_mode),
        .block_cnt (block_cnt)
    );

    typedef struct {
        bit           new_msg;
        logic [1:0]   mode;
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] pt;
        bit           last;
        logic [127:0] ct;
        int           cnt;
    } vec_t;

    vec_t vecs[6];

    localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_SP   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3     = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4     = 128'hf69f2445df4f9b17ad2b417be66c3710;

    // ---------------- reference AES (S-box built from GF(2^8) inverse) ----------------
    logic [7:0] sb_tab [256];

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = m_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] y, input int n);
        logic [7:0] l = y << n;
        logic [7:0] r = y >> (8 - n);
        return l | r;
    endfunction

    function automatic logic [7:0] m_sbox_calc(input logic [7:0] x);
        logic [7:0] y = 8'h01;
        for (int i = 0; i < 254; i++) y = m_mul(y, x);
        return y ^ m_rotl(y, 1) ^ m_rotl(y, 2) ^ m_rotl(y, 3) ^ m_rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] k [16];
        logic [7:0] rc = 8'h01;
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127 - 8*i -: 8];
            s[i] = pt[127 - 8*i -: 8] ^ k[i];
        end
        for (int r = 1; r <= 10; r++) begin
            k[0] = k[0] ^ sb_tab[k[13]] ^ rc;
            k[1] = k[1] ^ sb_tab[k[14]];
            k[2] = k[2] ^ sb_tab[k[15]];
            k[3] = k[3] ^ sb_tab[k[12]];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = m_xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
                    s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- check helpers and drivers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_cfg(input logic [1:0] mode, input logic [127:0] key, input logic [127:0] iv);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_mode  = mode;
        cfg_key   = key;
        cfg_iv    = iv;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] data, input bit last, input int limit, output bit ok);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (!in_ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int limit, output bit ok);
        int n = 0;
        while (!out_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic pop_one;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input int i);
        bit ok;
        if (vecs[i].new_msg) begin
            do_cfg(vecs[i].mode, vecs[i].key, vecs[i].iv);
            chk($sformatf("v%0d_busy_after_cfg", i), {127'd0, busy}, 128'd1);
        end
        send_block(vecs[i].pt, vecs[i].last, 200, ok);
        chk($sformatf("v%0d_accept", i), {127'd0, ok}, 128'd1);
        wait_out(200, ok);
        chk($sformatf("v%0d_out_valid", i), {127'd0, ok}, 128'd1);
        chk($sformatf("v%0d_data", i), out_data, vecs[i].ct);
        chk($sformatf("v%0d_last", i), {127'd0, out_last}, {127'd0, vecs[i].last});
        chk($sformatf("v%0d_cnt", i), {112'd0, block_cnt}, 128'(vecs[i].cnt));
        $display("vec %0d mode %0d out %h last %b cnt %0d", i, vecs[i].mode, out_data, out_last, block_cnt);
        pop_one();
        if (vecs[i].last) begin
            chk($sformatf("v%0d_idle_busy", i), {127'd0, busy}, 128'd0);
            chk($sformatf("v%0d_idle_cfg_ready", i), {127'd0, cfg_ready}, 128'd1);
            chk($sformatf("v%0d_empty", i), {127'd0, out_valid}, 128'd0);
        end
    endtask

    // Backpressure collection buffers.
    logic [127:0] rx_data [4];
    bit           rx_last [4];
    int           rx_got;

    // Global time limit so a stuck design still ends the run.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, ok3, ok4;
        logic [127:0] wrap_iv, exp1, exp2;

        for (int i = 0; i < 256; i++) sb_tab[i] = m_sbox_calc(8'(i));

        vecs[0] = '{1, 2'd0, K_FIPS, 128'd0, 128'h00112233445566778899aabbccddeeff, 1,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1};
        vecs[1] = '{1, 2'd1, K_SP, K_FIPS, P1, 0, 128'h7649abac8119b246cee98e9b12e9197d, 1};
        vecs[2] = '{0, 2'd1, K_SP, K_FIPS, P2, 1, 128'h5086cb9b507219ee95db113a917678b2, 2};
        vecs[3] = '{1, 2'd2, K_SP, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, P1, 0,
                    128'h874d6191b620e3261bef6864990db6ce, 1};
        vecs[4] = '{0, 2'd2, K_SP, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, P2, 1,
                    128'h9806f66b7970fdff8617187bb9fffdff, 2};
        vecs[5] = '{1, 2'd0, K_SP, 128'd0, P3, 1, 128'h43b1cd7f598ece23881b00e3ed030688, 1};

        reset = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_key = '0; cfg_iv = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_cfg_ready", {127'd0, cfg_ready}, 128'd1);
        chk("rst_in_ready",  {127'd0, in_ready},  128'd0);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data",  out_data, 128'd0);
        chk("rst_out_last",  {127'd0, out_last},  128'd0);
        chk("rst_busy",      {127'd0, busy},      128'd0);
        chk("rst_err",       {127'd0, err_mode},  128'd0);
        chk("rst_cnt",       {112'd0, block_cnt}, 128'd0);

        // Known-answer table
        for (int i = 0; i < 6; i++) begin
            run_vec(i);
            if (i == 4) chk("ctr_chain_end", dut.chain_reg, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01);
        end

        // CTR counter wrap in the low 32 bits
        wrap_iv = 128'hdeadbeef0123456789abcdefffffffff;
        exp1 = P1 ^ aes_ref(K_SP, wrap_iv);
        exp2 = P2 ^ aes_ref(K_SP, {wrap_iv[127:32], 32'h00000000});
        do_cfg(2'd2, K_SP, wrap_iv);
        send_block(P1, 1'b0, 200, ok);
        wait_out(200, ok);
        chk("wrap_valid1", {127'd0, ok}, 128'd1);
        chk("wrap_data1", out_data, exp1);
        $display("ctr wrap blk 1 out %h", out_data);
        pop_one();
        send_block(P2, 1'b1, 200, ok);
        wait_out(200, ok);
        chk("wrap_valid2", {127'd0, ok}, 128'd1);
        chk("wrap_data2", out_data, exp2);
        chk("wrap_last2", {127'd0, out_last}, 128'd1);
        $display("ctr wrap blk 2 out %h", out_data);
        pop_one();
        chk("wrap_chain", dut.chain_reg, {wrap_iv[127:32], 32'h00000001});

        // Backpressure: consumer stalled, two blocks fill the FIFO, then in_ready holds low
        out_ready = 1'b0;
        do_cfg(2'd0, K_SP, 128'd0);
        send_block(P1, 1'b0, 200, ok);
        chk("bp_accept1", {127'd0, ok}, 128'd1);
        send_block(P2, 1'b0, 200, ok);
        chk("bp_accept2", {127'd0, ok}, 128'd1);
        wait_cycles(30);
        chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
        chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
        chk("bp_cnt2", {112'd0, block_cnt}, 128'd2);
        rx_got = 0;
        fork
            begin : producer
                send_block(P3, 1'b0, 3000, ok3);
                send_block(P4, 1'b1, 3000, ok4);
            end
            begin : consumer
                int n = 0;
                bit r;
                while (rx_got < 4 && n < 3000) begin
                    @(negedge clk);
                    r = 1'($urandom_range(0, 1));
                    out_ready = r;
                    if (r && out_valid) begin
                        rx_data[rx_got] = out_data;
                        rx_last[rx_got] = out_last;
                        rx_got++;
                    end
                    n++;
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        chk("bp_accept3", {127'd0, ok3}, 128'd1);
        chk("bp_accept4", {127'd0, ok4}, 128'd1);
        chk("bp_got", 128'(rx_got), 128'd4);
        chk("bp_data0", rx_data[0], 128'h3ad77bb40d7a3660a89ecaf32466ef97);
        chk("bp_data1", rx_data[1], 128'hf5d3d58503b9699de785895a96fdbaaf);
        chk("bp_data2", rx_data[2], 128'h43b1cd7f598ece23881b00e3ed030688);
        chk("bp_data3", rx_data[3], 128'h7b0c785e27e8ad3f8223207104725dd4);
        chk("bp_lasts", {124'd0, rx_last[0], rx_last[1], rx_last[2], rx_last[3]}, 128'b0001);
        for (int i = 0; i < 4; i++) $display("bp blk %0d out %h last %b", i, rx_data[i], rx_last[i]);
        chk("bp_empty", {127'd0, out_valid}, 128'd0);

        // Illegal mode: one-cycle err pulse, nothing latched, stays idle
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_mode  = 2'd3;
        cfg_key   = 128'h1;
        cfg_iv    = 128'h2;
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_mode  = 2'd0;
        chk("err_pulse", {127'd0, err_mode}, 128'd1);
        chk("err_idle_busy", {127'd0, busy}, 128'd0);
        chk("err_cfg_ready", {127'd0, cfg_ready}, 128'd1);
        @(negedge clk);
        chk("err_pulse_end", {127'd0, err_mode}, 128'd0);
        chk("err_cnt_kept", {112'd0, block_cnt}, 128'd4);
        $display("illegal mode err pulse seen");

        // Reset in CORE with one block waiting in the FIFO
        do_cfg(2'd0, K_FIPS, 128'd0);
        send_block(P1, 1'b0, 200, ok);
        wait_out(200, ok);
        chk("rst_mid_fifo", {127'd0, ok}, 128'd1);
        send_block(P2, 1'b0, 200, ok);
        wait_cycles(3);
        chk("rst_mid_busy_before", {127'd0, busy}, 128'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_mid_busy", {127'd0, busy}, 128'd0);
        chk("rst_mid_cfg_ready", {127'd0, cfg_ready}, 128'd1);
        chk("rst_mid_cnt", {112'd0, block_cnt}, 128'd0);
        reset = 1'b0;
        $display("mid-message reset applied");
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
Multi-block AES-128 encryption engine that wraps one internal instance of the team's iterative `aes` core (clk, resetn, data_valid_in, data_in, key_in, res_valid_out, res_enc_out). It adds ECB/CBC/CTR chaining, valid/ready streaming on input and output, and a parametrised output FIFO. It sits between the host DMA stream and the single-block `aes` core, and gives the core exactly one block at a time.

Parameters:
CTR_W, 32, width of the counter field (LSBs of the chain register) incremented in CTR mode; legal range 8..128.
OUT_DEPTH, 2, output FIFO depth in blocks; legal range ≥1.
CNT_W, 16, width of the block_cnt status counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
cfg_valid  in  1  message configuration valid.
cfg_ready  out  1  high only in IDLE.
cfg_mode  in  2  0=ECB, 1=CBC, 2=CTR, 3=illegal.
cfg_key  in  128  AES-128 key.
cfg_iv  in  128  CBC IV or CTR initial counter block; ignored in ECB.
in_valid  in  1  plaintext block valid.
in_ready  out  1  plaintext block accepted when in_valid & in_ready.
in_data  in  128  plaintext block.
in_last  in  1  final block of the message.
out_valid  out  1  FIFO not empty.
out_ready  in  1  consumer accept.
out_data  out  128  ciphertext block at the FIFO head.
out_last  out  1  last flag of the FIFO head.
busy  out  1  high in any state other than IDLE.
err_mode  out  1  one-cycle pulse when cfg_mode==3 is presented.
block_cnt  out  CNT_W  blocks pushed to the FIFO since the last cfg accept; wraps modulo 2^CNT_W.

Behaviour:
- Reset state: state=IDLE, FIFO emptied, chain/key/data registers cleared to 0.
- Reset output values: cfg_ready=1 from the first cycle after reset; in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, err_mode=0, block_cnt=0.
- Internal core is driven with resetn = ~reset.
- Reset asserted mid-message: the in-flight block and all FIFO contents are discarded.
- States: IDLE, WAIT_IN, CORE.
- IDLE: cfg_ready=1.
  - cfg_valid with mode 0..2: latch key, mode and chain<=cfg_iv; clear block_cnt; go to WAIT_IN.
  - cfg_valid with mode 3: pulse err_mode for one cycle; nothing is latched; stay in IDLE.
- WAIT_IN: in_ready = (fifo_count < OUT_DEPTH). This reserves the FIFO slot for the in-flight block, so a push never meets a full FIFO.
  - On handshake: latch in_data and in_last.
  - Drive the core on the next cycle with data_valid_in=1 for exactly one cycle and key_in = latched key.
  - Core data_in by mode: ECB = in_data; CBC = in_data ^ chain; CTR = chain.
  - Go to CORE.
- CORE: in_ready=0. Wait for res_valid_out; the core latency is variable and is not assumed.
  - Result R by mode: ECB = res_enc_out; CBC = res_enc_out; CTR = res_enc_out ^ latched in_data.
  - Chain update: CBC sets chain <= res_enc_out. CTR sets chain[CTR_W-1:0] <= chain[CTR_W-1:0]+1 (mod 2^CTR_W) and leaves chain[127:CTR_W] unchanged.
  - In the same cycle: push {R, last} to the FIFO and increment block_cnt.
  - Next state: IDLE if last, else WAIT_IN.
- Output FIFO:
  - Pop on out_valid & out_ready.
  - A push and a pop in the same cycle keep the count unchanged.
  - out_data and out_last are valid whenever out_valid=1 and stay stable until popped.
  - No combinational path from out_ready to in_ready.
- A new cfg is accepted in IDLE even while the FIFO still holds blocks from the previous message.
- Output order equals input order.
- Throughput: at most one block per (core latency + 2) cycles.

Test Plan:
- ECB, key 000102030405060708090a0b0c0d0e0f, one block 00112233445566778899aabbccddeeff, in_last=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1, block_cnt=1, then back to IDLE with busy=0.
- CBC, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f:
  - P1 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d.
  - P2 ae2d8a571e03ac9c9eb76fac45af8e51 (last) -> 5086cb9b507219ee95db113a917678b2, out_last=1.
- CTR, same key, IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, same P1/P2:
  - Outputs 874d6191b620e3261bef6864990db6ce and 9806f66b7970fdff8617187bb9fffdff.
  - Chain register ends at ...fcfdff01.
- CTR wrap, IV with low 32 bits ffffffff: the second block's counter equals the IV with low 32 bits 00000000 and bits [127:32] unchanged; check against a reference-model ciphertext.
- Backpressure, OUT_DEPTH=2, out_ready=0, 4-block ECB message: in_ready drops after 2 accepts and no block is lost. Release out_ready with random toggling: 4 blocks arrive in order, out_last only on the 4th.
- cfg_mode=3 -> err_mode pulses 1 cycle and the block stays in IDLE. Reset asserted in CORE with 1 block in the FIFO -> next cycle out_valid=0, busy=0, cfg_ready=1; the following ECB vector passes.
